// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch controller.  Owns the program counter, drives the
// combinational instruction ROM and registers each returned word together
// with its PC.  The registered word goes to decode over a valid/ready
// handshake.  Redirects from execute replace the PC and drop any word that
// decode has not yet taken.  Any fetch attempt from an address at or beyond
// DEPTH raises a sticky fault that only reset clears.
//
// Optional feature: define FETCH_PERF_CNT_EN to build a 32-bit counter of
// words accepted by decode.  Without it, fetch_count is tied to zero and no
// counter register exists.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   rom_addr        word address to ROM (always equal to pc)
//   rom_instr       ROM data, valid in the same cycle as rom_addr
//   redirect_valid  one-cycle pulse: taken branch or jump
//   redirect_target new word address from execute
//   out_valid       out_instr/out_pc hold a fetched word
//   out_ready       decode accepts the word this cycle
//   out_instr       fetched instruction
//   out_pc          word address of out_instr
//   fault           sticky out-of-range fetch flag
//   fetch_count     accepted-instruction counter (zero when not built)
// ----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int N        = 32,
   parameter int DEPTH    = 32,
   parameter int RESET_PC = 0
) (
   input  logic          clk,
   input  logic          reset,
   output logic [N-1:0]  rom_addr,
   input  logic [N-1:0]  rom_instr,
   input  logic          redirect_valid,
   input  logic [N-1:0]  redirect_target,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_instr,
   output logic [N-1:0]  out_pc,
   output logic          fault,
   output logic [31:0]   fetch_count
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   localparam logic [N-1:0] DEPTH_W    = N'(DEPTH);
   localparam logic [N-1:0] RESET_PC_W = N'(RESET_PC);
   localparam logic         BOOT_FAULT = (RESET_PC >= DEPTH);

   state_t         state_q, state_d;
   logic [N-1:0]   pc_q, pc_d;
   logic           out_valid_q, out_valid_d;
   logic [N-1:0]   out_instr_q, out_instr_d;
   logic [N-1:0]   out_pc_q, out_pc_d;
   logic           fault_q, fault_d;

   logic           advance;
   logic           pc_in_range;

   assign advance     = !out_valid_q || out_ready;
   // Range check is done on pc itself, so an illegal address never lets the
   // ROM word through into out_instr.
   assign pc_in_range = (pc_q < DEPTH_W);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      fault_d     = fault_q;

      unique case (state_q)
         ST_BOOT: begin
            // Dead cycle after reset; a redirect here still takes effect.
            if (redirect_valid) begin
               pc_d    = redirect_target;
               state_d = ST_RUN;
            end else if (BOOT_FAULT) begin
               fault_d = 1'b1;
               state_d = ST_FAULT;
            end else begin
               state_d = ST_RUN;
            end
         end

         ST_RUN, ST_HOLD: begin
            if (redirect_valid) begin
               // Drop the held word; the capture slot on this edge is the
               // single bubble a redirect costs.
               pc_d        = redirect_target;
               out_valid_d = 1'b0;
               state_d     = ST_RUN;
            end else if (advance) begin
               if (pc_in_range) begin
                  out_instr_d = rom_instr;
                  out_pc_d    = pc_q;
                  out_valid_d = 1'b1;
                  pc_d        = pc_q + 1'b1;
                  state_d     = ST_RUN;
               end else begin
                  out_valid_d = 1'b0;
                  fault_d     = 1'b1;
                  state_d     = ST_FAULT;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end

         ST_FAULT: begin
            // Frozen until reset; redirects are ignored.
            out_valid_d = 1'b0;
            fault_d     = 1'b1;
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_PC_W;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         fault_q     <= fault_d;
      end
   end

   assign rom_addr  = pc_q;
   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_pc    = out_pc_q;
   assign fault     = fault_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q, fetch_count_d;

   // A word dropped by a redirect on the same edge it is accepted still
   // counts, since decode did take it.
   always_comb begin
      fetch_count_d = fetch_count_q;
      if (out_valid_q && out_ready) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count_q <= 32'd0;
      end else begin
         fetch_count_q <= fetch_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
`else
   assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// Bench for fetch_sequencer.  ROM word i = 0xA0000000 + i.  Directed
// scenarios follow the expected fetch behaviour; a randomized phase compares
// against a word-stream reference model (next address to fetch, currently
// presented word, sticky fault) built from the fetch rules.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam int N     = 32;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  rom_addr;
   logic [N-1:0]  rom_instr;
   logic          redirect_valid;
   logic [N-1:0]  redirect_target;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_instr;
   logic [N-1:0]  out_pc;
   logic          fault;
   logic [31:0]   fetch_count;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic          m_valid;
   logic [31:0]   m_pc;
   logic [31:0]   m_next;
   logic          m_fault;
   logic          m_boot;
   logic [31:0]   m_acc;

   always #5 clk = ~clk;

   assign rom_instr = 32'hA000_0000 + rom_addr;

   fetch_sequencer #(.N(N), .DEPTH(DEPTH), .RESET_PC(0)) dut (
      .clk             (clk),
      .reset           (reset),
      .rom_addr        (rom_addr),
      .rom_instr       (rom_instr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .fault           (fault),
      .fetch_count     (fetch_count)
   );

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'hA000_0000 + a;
   endfunction

   function automatic logic [31:0] exp_count();
`ifdef FETCH_PERF_CNT_EN
      return m_acc;
`else
      return 32'd0;
`endif
   endfunction

   // Advance the model by one edge using the current inputs, then let the
   // DUT take the edge and sample 1 time unit later.
   task automatic tick();
      if (reset) begin
         m_valid = 1'b0; m_next = 32'd0; m_fault = 1'b0; m_boot = 1'b1;
         m_acc = 32'd0;
      end else begin
         if (m_valid && out_ready) m_acc = m_acc + 32'd1;
         if (m_fault) begin
            m_valid = 1'b0;
         end else if (redirect_valid) begin
            m_next = redirect_target; m_valid = 1'b0; m_boot = 1'b0;
         end else if (m_boot) begin
            m_boot = 1'b0;
         end else if (!m_valid || out_ready) begin
            if (m_next < DEPTH) begin
               m_valid = 1'b1; m_pc = m_next; m_next = m_next + 32'd1;
            end else begin
               m_valid = 1'b0; m_fault = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || fault !== 1'b0 || rom_addr !== 32'd0 ||
          out_pc !== 32'd0 || out_instr !== 32'd0 || fetch_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%0b fault=%0b addr=%0d pc=%0d instr=%h cnt=%0d, want 0s",
                  out_valid, fault, rom_addr, out_pc, out_instr, fetch_count);
      end
      tick();  // BOOT dead cycle
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL boot_bubble: out_valid=%0b want 0", out_valid);
      end else $display("boot: out_valid=0");
   endtask

   task automatic test_stream();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(i) || out_instr !== rom_word(32'(i))) begin
            errors++;
            $display("FAIL stream_%0d: valid=%0b pc=%0d instr=%h want 1 %0d %h",
                     i, out_valid, out_pc, out_instr, i, rom_word(32'(i)));
         end else $display("stream: pc=%0d instr=%h", out_pc, out_instr);
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'd2 || out_instr !== 32'hA000_0002 ||
             rom_addr !== 32'd3) begin
            errors++;
            $display("FAIL stall_%0d: valid=%0b pc=%0d instr=%h addr=%0d want 1 2 a0000002 3",
                     i, out_valid, out_pc, out_instr, rom_addr);
         end else $display("stall: held pc=%0d", out_pc);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd3 || out_instr !== 32'hA000_0003) begin
         errors++;
         $display("FAIL stall_release: pc=%0d instr=%h want 3 a0000003", out_pc, out_instr);
      end else $display("release: pc=%0d instr=%h", out_pc, out_instr);
   endtask

   task automatic test_redirect();
      tick(); tick();  // words 4, 5
      out_ready = 1'b0;
      tick();          // word 5 held, not accepted
      checks++;
      if (out_pc !== 32'd5 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL redirect_setup: pc=%0d valid=%0b want 5 1", out_pc, out_valid);
      end
      redirect_valid = 1'b1; redirect_target = 32'd16;
      tick();
      redirect_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || rom_addr !== 32'd16) begin
         errors++;
         $display("FAIL redirect_bubble: valid=%0b addr=%0d want 0 16", out_valid, rom_addr);
      end else $display("redirect: bubble, addr=16");
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd16 || out_instr !== 32'hA000_0010) begin
         errors++;
         $display("FAIL redirect_word: valid=%0b pc=%0d instr=%h want 1 16 a0000010",
                  out_valid, out_pc, out_instr);
      end else $display("redirect: pc=%0d instr=%h", out_pc, out_instr);
   endtask

   task automatic test_fault();
      redirect_valid = 1'b1; redirect_target = 32'd30;
      tick();
      redirect_valid = 1'b0;
      for (int i = 30; i < 32; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(i) || out_instr !== rom_word(32'(i)) ||
             fault !== 1'b0) begin
            errors++;
            $display("FAIL edge_word_%0d: valid=%0b pc=%0d fault=%0b", i, out_valid, out_pc, fault);
         end else $display("edge: pc=%0d instr=%h", out_pc, out_instr);
      end
      tick();
      checks++;
      if (fault !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL fault_raise: fault=%0b valid=%0b want 1 0", fault, out_valid);
      end else $display("fault raised at addr=%0d", rom_addr);
      redirect_valid = 1'b1; redirect_target = 32'd4;
      tick();
      redirect_valid = 1'b0;
      tick();
      checks++;
      if (fault !== 1'b1 || out_valid !== 1'b0 || rom_addr !== 32'd32) begin
         errors++;
         $display("FAIL fault_sticky: fault=%0b valid=%0b addr=%0d want 1 0 32",
                  fault, out_valid, rom_addr);
      end else $display("fault: redirect ignored");
      do_reset();
      tick(); tick();
      checks++;
      if (fault !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'd0) begin
         errors++;
         $display("FAIL fault_clear: fault=%0b valid=%0b pc=%0d want 0 1 0",
                  fault, out_valid, out_pc);
      end else $display("fault cleared, pc=%0d", out_pc);
   endtask

   task automatic test_reset_redirect();
      tick(); tick();
      reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'd9;
      tick();
      reset = 1'b0; redirect_valid = 1'b0;
      checks++;
      if (rom_addr !== 32'd0 || out_valid !== 1'b0 || out_pc !== 32'd0) begin
         errors++;
         $display("FAIL reset_redirect: addr=%0d valid=%0b pc=%0d want 0 0 0",
                  rom_addr, out_valid, out_pc);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_redirect_boot: valid=%0b want 0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd0) begin
         errors++;
         $display("FAIL reset_redirect_first: valid=%0b pc=%0d want 1 0", out_valid, out_pc);
      end else $display("reset+redirect: restarted at pc=0");
   endtask

   task automatic test_count();
      int acc;
      int stalls;
      int cyc;
      out_ready = 1'b1;
      do_reset();
      acc = 0; stalls = 0; cyc = 0;
      while (acc < 10 && cyc < 100) begin
         out_ready = !(cyc % 3 == 2 && stalls < 4);
         if (!out_ready && out_valid) stalls++;
         if (out_valid && out_ready) acc++;
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      checks++;
      if (acc != 10) begin
         errors++;
         $display("FAIL count_timeout: accepted=%0d want 10", acc);
      end
      checks++;
`ifdef FETCH_PERF_CNT_EN
      if (fetch_count !== 32'd10) begin
         errors++;
         $display("FAIL fetch_count: got %0d want 10", fetch_count);
      end else $display("fetch_count=%0d after 10 accepts, %0d stalls", fetch_count, stalls);
`else
      if (fetch_count !== 32'd0) begin
         errors++;
         $display("FAIL fetch_count: got %0d want 0", fetch_count);
      end else $display("fetch_count=0 (counter not built), %0d stalls", stalls);
`endif
      out_ready = 1'b1;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         reset           = ($urandom_range(0, 99) == 0);
         out_ready       = ($urandom_range(0, 3) != 0);
         redirect_valid  = ($urandom_range(0, 11) == 0);
         redirect_target = 32'($urandom_range(0, 34));
         tick();
         checks++;
         if (out_valid !== m_valid || rom_addr !== m_next || fault !== m_fault ||
             fetch_count !== exp_count() ||
             (m_valid && (out_pc !== m_pc || out_instr !== rom_word(m_pc)))) begin
            errors++;
            $display("FAIL random_%0d: valid=%0b addr=%0d fault=%0b pc=%0d instr=%h cnt=%0d want %0b %0d %0b %0d %h %0d",
                     i, out_valid, rom_addr, fault, out_pc, out_instr, fetch_count,
                     m_valid, m_next, m_fault, m_pc, rom_word(m_pc), exp_count());
         end
      end
      reset = 1'b0; redirect_valid = 1'b0;
      $display("random: 400 cycles compared");
   endtask

   initial begin
      reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
      m_valid = 1'b0; m_pc = '0; m_next = '0; m_fault = 1'b0; m_boot = 1'b1; m_acc = '0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_fault();
      test_reset_redirect();
      test_count();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that owns the program counter and sequences the combinational instruction ROM.
- Drives the ROM word address and registers the returned word with its PC.
- Presents the word to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes the held word on redirect.
- Enters a sticky fault state on any out-of-range fetch address.

Parameters:
N, 32, data/address width
DEPTH, 32, number of ROM words; legal PC range 0..DEPTH-1
RESET_PC, 0, word address fetched first after reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
rom_addr  output  N  word address to ROM (combinational from pc)
rom_instr  input  N  ROM data, valid same cycle as rom_addr
redirect_valid  input  1  one-cycle pulse: taken branch or jump
redirect_target  input  N  new word address; already computed by execute
out_valid  output  1  out_instr/out_pc hold a fetched word
out_ready  input  1  decode accepts word this cycle
out_instr  output  N  fetched instruction
out_pc  output  N  word address of out_instr
fault  output  1  sticky out-of-range fetch flag
fetch_count  output  32  accepted-instruction counter (see Optional Feature)

Behaviour:
- One clock; reset is synchronous and active-high; all state updates on rising clk.
- Reset values: pc=RESET_PC, state=BOOT, out_valid=0, out_instr=0, out_pc=0, fault=0, fetch_count=0.
- Reset asserted mid-operation overrides redirect, handshake and fault on that edge.
- rom_addr = pc at all times (combinational). ROM read latency is 0; the word is captured at the same edge.
- "advance" = (!out_valid || out_ready).
- States:
  - BOOT: one dead cycle after reset, out_valid stays 0. Next state RUN, or FAULT if RESET_PC >= DEPTH.
  - RUN, when advance:
    - If pc < DEPTH: out_instr<=rom_instr, out_pc<=pc, out_valid<=1, pc<=pc+1.
    - If pc >= DEPTH: out_valid<=0, fault<=1, next state FAULT.
  - RUN, when !advance: all outputs and pc hold, next state HOLD.
  - HOLD: out_valid=1 with registers stable. When out_ready=1, perform the RUN advance action on that edge and return to RUN.
  - FAULT: out_valid=0, pc frozen, fault=1. Redirects are ignored. Only reset exits.
- Redirect (RUN, HOLD or BOOT):
  - Highest priority after reset.
  - On that edge: pc<=redirect_target, out_valid<=0 (held/unaccepted word dropped), next state RUN.
  - No fetch is captured on the redirect edge, so there is exactly one bubble.
  - If out_valid && out_ready on the same edge, the word counts as accepted by decode (fetch_count increments), then is cleared.
  - A target >= DEPTH is accepted into pc. The fault is raised on the next RUN fetch attempt.
- Arithmetic: pc+1 is N-bit wrap. The range check against DEPTH always happens before the ROM word is used.
- Throughput: 1 word/cycle when out_ready is held high.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: fetch_count increments by 1 on every edge with out_valid && out_ready && !reset. It wraps at 2^32 and clears on reset.
- Undefined: fetch_count is tied to 0 and no counter register is generated. All other behaviour is identical.

Test Plan:
- Bench ROM model word i = 0xA0000000+i.
- Reset, out_ready=1 → out_valid=0 during BOOT. Then (out_pc,out_instr) = (0,0xA0000000), (1,0xA0000001), (2,0xA0000002) on consecutive cycles.
- out_ready=0 for 3 cycles while out_pc=2 → out_pc=2 and out_instr=0xA0000002 stable, pc stays 3. On release, the next word is (3,0xA0000003).
- redirect_valid pulse with target=16 while holding unaccepted word 5 → next cycle out_valid=0. The following cycle gives (16,0xA0000010); word 5 is never accepted.
- Free-run from pc=30 with DEPTH=32 → words 30 and 31 delivered, then fault=1, out_valid=0. A redirect to 4 is ignored. Reset clears fault and restarts at 0.
- Reset asserted together with redirect_valid (target=9) → pc=RESET_PC, out_valid=0, state BOOT.
- FETCH_PERF_CNT_EN defined, 10 accepted words with 4 stall cycles interleaved → fetch_count=10. Undefined → fetch_count=0 throughout.
